// File: rtl/math_subtractor_brent_kung_pipe_016.sv
// Two-stage pipelined N-bit subtractor (a + ~b + ~bin) built on a Brent-Kung prefix tree.
// Define BK_SUB_OVERFLOW_EN to add the registered signed-overflow output o_ovf.
module math_subtractor_brent_kung_pipe_016 #(
  parameter int unsigned N = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_bin,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_diff,
  output logic         o_borrow
`ifdef BK_SUB_OVERFLOW_EN
  ,
  output logic         o_ovf
`endif
);

  localparam int unsigned LG = $clog2(N);

  logic         s1_valid;
  logic [N-1:0] s1_p;
  logic [N-1:0] s1_g;
  logic         s1_cin;
`ifdef BK_SUB_OVERFLOW_EN
  logic         s1_sa;
  logic         s1_sb;
`endif

  logic         s2_load;
  logic         s1_advance;
  logic [N-1:0] gg;
  logic [N-1:0] pp;
  logic [N:0]   c;
  logic [N-1:0] sum;

  assign s2_load    = !o_valid || i_ready;
  assign s1_advance = s1_valid && s2_load;
  assign o_ready    = !s1_valid || s1_advance;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_cin   <= 1'b0;
`ifdef BK_SUB_OVERFLOW_EN
      s1_sa    <= 1'b0;
      s1_sb    <= 1'b0;
`endif
    end else if (o_ready) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_p   <= i_a ^ ~i_b;
        s1_g   <= i_a & ~i_b;
        s1_cin <= ~i_bin;
`ifdef BK_SUB_OVERFLOW_EN
        s1_sa  <= i_a[N-1];
        s1_sb  <= i_b[N-1];
`endif
      end
    end
  end

  // Up-sweep builds power-of-two group terms; down-sweep fills the remaining prefixes.
  // After both passes gg[i]/pp[i] are generate/propagate over bits [i:0].
  always_comb begin
    gg = s1_g;
    pp = s1_p;
    for (int unsigned l = 0; l < LG; l++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
          pp[i] = pp[i] & pp[i - (1 << l)];
        end
      end
    end
    for (int unsigned k = 1; k < LG; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if ((i + 1 > (1 << (LG - 1 - k))) &&
            (((i + 1) % (2 << (LG - 1 - k))) == (1 << (LG - 1 - k)))) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << (LG - 1 - k))]);
          pp[i] = pp[i] & pp[i - (1 << (LG - 1 - k))];
        end
      end
    end
  end

  always_comb begin
    c    = '0;
    c[0] = s1_cin;
    for (int unsigned i = 0; i < N; i++) begin
      c[i + 1] = gg[i] | (pp[i] & s1_cin);
    end
    sum = s1_p ^ c[N-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_diff   <= '0;
      o_borrow <= 1'b0;
`ifdef BK_SUB_OVERFLOW_EN
      o_ovf    <= 1'b0;
`endif
    end else if (s2_load) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_diff   <= sum;
        o_borrow <= ~c[N];
`ifdef BK_SUB_OVERFLOW_EN
        o_ovf    <= (s1_sa != s1_sb) && (sum[N-1] != s1_sa);
`endif
      end
    end
  end

endmodule

// File: doc/math_subtractor_brent_kung_pipe_016.md
MATH_SUBTRACTOR_BRENT_KUNG_PIPE_016 -- requirements
Module: math_subtractor_brent_kung_pipe_016

Interface
REQ-001 Parameter N, default 16, shall set the operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 i_clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  shall be the asynchronous, active-low reset.
REQ-004 i_valid  input  1  shall mark the input operands as valid.
REQ-005 o_ready  output  1  shall indicate that the block accepts input this cycle.
REQ-006 i_a  input  N  shall be the minuend.
REQ-007 i_b  input  N  shall be the subtrahend.
REQ-008 i_bin  input  1  shall be the borrow-in.
REQ-009 o_valid  output  1  shall mark the result as valid.
REQ-010 i_ready  input  1  shall indicate that the downstream consumer accepts the result.
REQ-011 o_diff  output  N  shall carry the difference.
REQ-012 o_borrow  output  1  shall carry the borrow-out.

Function
REQ-013 The block shall compute o_diff = (i_a - i_b - i_bin) mod 2^N.
- o_borrow = 1 iff i_a < i_b + i_bin, unsigned.
REQ-014 Arithmetic shall be a + ~b + ~bin through Brent-Kung prefix logic; borrow = NOT carry-out.
REQ-015 Pipeline shall be two stages:
- S1 registers bitwise P, G and carry-in.
- Prefix tree and sum are combinational from S1.
- S2 registers diff, borrow and flags.
REQ-016 Latency shall be exactly 2 cycles from input handshake (i_valid & o_ready) to o_valid, with no stall.
REQ-017 Throughput shall be one result per cycle while i_ready = 1.
REQ-018 S2 shall load when S2 is empty or i_ready = 1; S1 shall load when S1 is empty or S1 advances.
REQ-019 o_ready = NOT s1_valid OR s1_advance (combinational).
- The path i_ready -> o_ready is permitted.
- No data path shall run combinationally from input to output.
REQ-020 While o_valid = 1 and i_ready = 0, o_diff, o_borrow and o_valid shall hold stable.
REQ-021 When the pipeline is full and i_ready = 0, o_ready shall be 0 and no input shall be lost or duplicated.
REQ-022 When a result retires and a new input is accepted in the same cycle, both shall complete without a bubble.
REQ-023 Operands with i_valid = 0 shall not change any stage register or valid bit.

Reset
REQ-024 Asserting i_rst_n low shall asynchronously clear s1_valid, o_valid, o_diff, o_borrow and all S1 data registers (and o_ovf when present) to 0.
REQ-025 In-flight operations at reset shall be discarded, never emitted.
REQ-026 o_ready shall be 1 on the first cycle after reset deassertion.

Configuration
REQ-027 With macro BK_SUB_OVERFLOW_EN defined, the block shall add output o_ovf (1 bit), registered in S2.
- o_ovf shall equal two's-complement signed overflow: (a[N-1] != b[N-1]) AND (diff[N-1] != a[N-1]).
- S1 shall additionally register both sign bits.
REQ-028 Without BK_SUB_OVERFLOW_EN, the port o_ovf and all associated registers shall be absent; all other behaviour is identical.

Verification
REQ-029 Reset, then a=0x0000, b=0x0001, bin=0 with i_ready=1 -> 2 cycles later o_valid=1, o_diff=0xFFFF, o_borrow=1.
REQ-030 a=0x8000, b=0x0001, bin=0 -> o_diff=0x7FFF, o_borrow=0; with BK_SUB_OVERFLOW_EN, o_ovf=1.
REQ-031 a=0x1234, b=0x1234, bin=1 -> o_diff=0xFFFF, o_borrow=1. Same operands with bin=0 -> o_diff=0x0000, o_borrow=0.
REQ-032 Backpressure sequence:
- Hold i_ready=0 and offer 3 back-to-back inputs.
- Exactly 2 shall be accepted; o_ready=0 thereafter; o_diff stays stable.
- Release i_ready: results emerge in order, one per cycle, and the 3rd is then accepted.
REQ-033 Streaming: 1000 random back-to-back operand sets with i_ready=1 -> one result per cycle after the 2-cycle fill, all matching a - b - bin reference model.
REQ-034 Mid-operation reset: with 2 operations in flight, pulse i_rst_n low between clock edges -> o_valid=0 immediately, no stale result after release, o_ready=1.
